// File: rtl/serial_subtractor_32_bit.sv
// serial_subtractor_32_bit: slice-serial d = a - b - bin with start/busy/done handshake
module serial_subtractor_32_bit #(
    parameter int N_BITS  = 32,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] d,
    output logic              bout,
    output logic              ovf
);
    localparam int STEPS = N_BITS / SLICE_W;
    localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [N_BITS-1:0]          a_q, b_q;
    logic                       brw_q;
    logic [N_BITS-SLICE_W-1:0]  part_q;
    logic [N_BITS-1:0]          d_q;
    logic                       bout_q, ovf_q, done_q;
    logic [SLICE_W:0]           slice_d;
    logic [N_BITS-1:0]          res_d;

    // Low slice of the shifting operands minus the running borrow; top bit is the new borrow
    always_comb begin
        slice_d = {1'b0, a_q[SLICE_W-1:0]} - {1'b0, b_q[SLICE_W-1:0]} - {{SLICE_W{1'b0}}, brw_q};
        res_d   = {slice_d[SLICE_W-1:0], part_q};
    end

    // Handshake FSM and slice datapath; results only move on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            part_q  <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q != RUN) begin
            done_q  <= 1'b0;
            state_q <= start ? RUN : IDLE;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                brw_q  <= bin;
                cnt_q  <= '0;
                part_q <= '0;
            end
        end else begin
            a_q   <= a_q >> SLICE_W;
            b_q   <= b_q >> SLICE_W;
            brw_q <= slice_d[SLICE_W];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                d_q     <= res_d;
                bout_q  <= slice_d[SLICE_W];
                ovf_q   <= (a_q[SLICE_W-1] != b_q[SLICE_W-1]) && (res_d[N_BITS-1] != a_q[SLICE_W-1]);
                done_q  <= 1'b1;
                state_q <= DONE;
            end else begin
                part_q[cnt_q*SLICE_W +: SLICE_W] <= slice_d[SLICE_W-1:0];
            end
        end
    end

    assign busy = state_q == RUN;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_32_bit.sv
// tb_serial_subtractor_32_bit: randomized self-checking bench against an arithmetic reference
module tb_serial_subtractor_32_bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, ovf;
    logic [31:0] d;

    int checks = 0;
    int passed = 0;
    logic [31:0] last_d = '0;
    logic        last_bout = 1'b0, last_ovf = 1'b0;

    serial_subtractor_32_bit dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0] full;
        logic        o;
        full = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        o = (x[31] != y[31]) && (full[31] != x[31]);
        return {1'b0, full[32], o, full[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Issues one subtraction, scrambles inputs mid-run, checks timing and result at T0+8
    task automatic do_sub(input logic [31:0] x, input logic [31:0] y, input logic bi, input string name);
        logic [34:0] r;
        r = ref_sub(x, y, bi);
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy@T0"}, {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            a = $urandom; b = $urandom; bin = 1'($urandom);
            @(posedge clk); #1;
            if (k < 8) begin
                if (busy !== 1'b1 || done !== 1'b0 || d !== last_d || bout !== last_bout || ovf !== last_ovf) begin
                    checks++;
                    $display("FAIL %s run k=%0d: busy=%b done=%b d=%0h bout=%b ovf=%b expected busy=1 done=0 d=%0h bout=%b ovf=%b",
                             name, k, busy, done, d, bout, ovf, last_d, last_bout, last_ovf);
                end
            end
        end
        chk({name, " done"}, {62'd0, done, busy}, {62'd0, 2'b10});
        chk({name, " d"}, {32'd0, d}, {32'd0, r[31:0]});
        chk({name, " bout/ovf"}, {62'd0, bout, ovf}, {62'd0, r[33], r[32]});
        last_d = r[31:0]; last_bout = r[33]; last_ovf = r[32];
        @(posedge clk); #1;
        chk({name, " done drop"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic test_reset();
        #3;
        chk("reset async", {29'd0, busy, done, bout, ovf, d}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("reset idle", {29'd0, busy, done, bout, ovf, d}, 64'd0);
    endtask

    task automatic test_plan_vectors();
        do_sub(32'd4200000021, 32'd980000, 1'b0, "plan1");
        do_sub(32'd12500002, 32'd3100030, 1'b1, "plan2");
        do_sub(32'd1, 32'd2, 1'b0, "wrap1");
        do_sub(32'd0, 32'd0, 1'b1, "wrap2");
        do_sub(32'h80000000, 32'd1, 1'b0, "ovf1");
        do_sub(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, "ovf2");
        do_sub(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "allones");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) do_sub($urandom, $urandom, 1'($urandom), "rand");
    endtask

    task automatic test_ignored_start();
        logic [34:0] r;
        int dones;
        r = ref_sub(32'hDEADBEEF, 32'h12345678, 1'b1);
        dones = 0;
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h12345678; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin a = 32'h11111111; b = 32'h99999999; bin = 1'b0; start = 1'b1; end
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
            if (done) dones++;
            if (k == 8) begin
                chk("ignored done@T0+8", {63'd0, done}, 64'd1);
                chk("ignored d", {32'd0, d}, {32'd0, r[31:0]});
                chk("ignored bout/ovf", {62'd0, bout, ovf}, {62'd0, r[33], r[32]});
            end
            @(negedge clk);
        end
        chk("ignored single done", 64'(dones), 64'd1);
        last_d = r[31:0]; last_bout = r[33]; last_ovf = r[32];
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        @(negedge clk);
        a = 32'h01234567; b = 32'h00000001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("abort outputs", {29'd0, busy, done, bout, ovf, d}, 64'd0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("abort no done", 64'(dones), 64'd0);
        last_d = '0; last_bout = 1'b0; last_ovf = 1'b0;
        do_sub(32'd500, 32'd499, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [34:0] r1, r2;
        r1 = ref_sub(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
        r2 = ref_sub(32'h00000005, 32'h00000009, 1'b1);
        @(negedge clk);
        a = 32'hCAFEF00D; b = 32'h0BADBEEF; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b first done", {62'd0, done, busy}, {62'd0, 2'b10});
        chk("b2b first d", {32'd0, d}, {32'd0, r1[31:0]});
        a = 32'h00000005; b = 32'h00000009; bin = 1'b1;
        @(posedge clk); #1;
        chk("b2b accept", {62'd0, done, busy}, {62'd0, 2'b01});
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("b2b still running", {62'd0, done, busy}, {62'd0, 2'b01});
        chk("b2b d held", {32'd0, d}, {32'd0, r1[31:0]});
        @(posedge clk); #1;
        chk("b2b second done", {62'd0, done, busy}, {62'd0, 2'b10});
        chk("b2b second result", {31'd0, bout, ovf, d}, {31'd0, r2[33], r2[32], r2[31:0]});
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random();
        test_ignored_start();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
